// File: rtl/eprisc_gpr_pkg.sv
// Shared types, constants and the architectural-to-physical index mapping
// for the paged epRISC general-purpose register file.
package eprisc_gpr_pkg;

    localparam int IDX_W  = 4;
    localparam int PAGE_W = 4;
    localparam int PHYS_W = 8;

    typedef enum logic {
        GPR_CLEAR,
        GPR_RUN
    } gprState_t;

    typedef struct packed {
        logic              valid;
        logic [PHYS_W-1:0] phys;
    } gprPhys_t;

    // Global indices ignore the page; the rest land in the page's private slice.
    function automatic gprPhys_t gpr_phys_index(
        input logic [IDX_W-1:0]  idx,
        input logic [PAGE_W-1:0] page,
        input int                pages,
        input int                regsPerPage,
        input int                globalRegs
    );
        gprPhys_t result;
        int       idxInt;
        int       pageInt;
        idxInt  = int'(idx);
        pageInt = int'(page);
        result  = '0;
        if (idxInt >= regsPerPage) begin
            result.valid = 1'b0;
        end else if (idxInt < globalRegs) begin
            result.valid = 1'b1;
            result.phys  = PHYS_W'(idxInt);
        end else if (pageInt >= pages) begin
            result.valid = 1'b0;
        end else begin
            result.valid = 1'b1;
            result.phys  = PHYS_W'(globalRegs + pageInt * (regsPerPage - globalRegs)
                                   + (idxInt - globalRegs));
        end
        return result;
    endfunction

endpackage

// File: rtl/eprisc_gpr_paged_if.sv
// Access bus between the decode/writeback stages (master) and the paged
// register file (slave).
interface eprisc_gpr_paged_if
    import eprisc_gpr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
);

    logic [PAGE_W-1:0]            iPage;
    logic                         iClear;
    logic                         oBusy;
    logic [RD_PORTS-1:0]          iRdEn;
    logic [RD_PORTS*IDX_W-1:0]    iRdAddr;
    logic [RD_PORTS*DATA_W-1:0]   oRdData;
    logic [WR_PORTS-1:0]          iWrEn;
    logic [WR_PORTS*IDX_W-1:0]    iWrAddr;
    logic [WR_PORTS*DATA_W-1:0]   iWrData;

    modport master (
        output iPage, iClear, iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData,
        input  oBusy, oRdData
    );

    modport slave (
        input  iPage, iClear, iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData,
        output oBusy, oRdData
    );

endinterface

// File: rtl/eprisc_gpr_clear_seq.sv
// Clear sequencer: walks every physical entry writing zero after reset or on
// request, then hands the array over to normal operation.
module eprisc_gpr_clear_seq
    import eprisc_gpr_pkg::*;
#(
    parameter int TOTAL  = 52,
    parameter int ADDR_W = 6
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    output logic              oBusy,
    output logic              oClrWe,
    output logic [ADDR_W-1:0] oClrAddr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);

    gprState_t         state;
    gprState_t         stateNext;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] countNext;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= GPR_CLEAR;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // The last clear write and the hand-over to RUN happen on the same edge.
    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            GPR_CLEAR: begin
                if (count == LAST) begin
                    stateNext = GPR_RUN;
                    countNext = '0;
                end else begin
                    countNext = count + 1'b1;
                end
            end
            GPR_RUN: begin
                if (iClear) begin
                    stateNext = GPR_CLEAR;
                    countNext = '0;
                end
            end
        endcase
    end

    assign oBusy    = (state == GPR_CLEAR);
    assign oClrWe   = (state == GPR_CLEAR);
    assign oClrAddr = count;

endmodule

// File: rtl/eprisc_gpr_paged.sv
// Paged general-purpose register file: shared global window plus per-page
// private registers. Define EPRISC_GPR_BYPASS_EN for write-to-read bypass.
module eprisc_gpr_paged
    import eprisc_gpr_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int RD_PORTS      = 2,
    parameter int WR_PORTS      = 2,
    parameter int PAGES         = 4,
    parameter int REGS_PER_PAGE = 16,
    parameter int GLOBAL_REGS   = 4
) (
    input logic               iClk,
    input logic               iRst,
    eprisc_gpr_paged_if.slave bus
);

    localparam int TOTAL  = GLOBAL_REGS + PAGES * (REGS_PER_PAGE - GLOBAL_REGS);
    localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              busy;
    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;

    logic [DATA_W-1:0] regs [DEPTH];

    gprPhys_t          rdMap  [RD_PORTS];
    gprPhys_t          wrMap  [WR_PORTS];
    logic [ADDR_W-1:0] rdAddr [RD_PORTS];
    logic [ADDR_W-1:0] wrAddr [WR_PORTS];
    logic [DATA_W-1:0] rdNext [RD_PORTS];
    logic [DATA_W-1:0] rdQ    [RD_PORTS];
    logic [RD_PORTS*DATA_W-1:0] rdFlat;

    eprisc_gpr_clear_seq #(
        .TOTAL  (TOTAL),
        .ADDR_W (ADDR_W)
    ) uClearSeq (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClear   (bus.iClear),
        .oBusy    (busy),
        .oClrWe   (clrWe),
        .oClrAddr (clrAddr)
    );

    assign bus.oBusy = busy;

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rdMap[r]  = gpr_phys_index(bus.iRdAddr[r*IDX_W +: IDX_W], bus.iPage,
                                       PAGES, REGS_PER_PAGE, GLOBAL_REGS);
            rdAddr[r] = ADDR_W'(rdMap[r].phys);
        end
        for (int w = 0; w < WR_PORTS; w++) begin
            wrMap[w]  = gpr_phys_index(bus.iWrAddr[w*IDX_W +: IDX_W], bus.iPage,
                                       PAGES, REGS_PER_PAGE, GLOBAL_REGS);
            wrAddr[w] = ADDR_W'(wrMap[w].phys);
        end
    end

    // Later ports overwrite earlier ones, so the highest-index writer wins.
    always_ff @(posedge iClk) begin
        if (clrWe) begin
            regs[clrAddr] <= '0;
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (bus.iWrEn[w] && wrMap[w].valid) begin
                    regs[wrAddr[w]] <= bus.iWrData[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rdNext[r] = '0;
            if (!busy && rdMap[r].valid) begin
                rdNext[r] = regs[rdAddr[r]];
`ifdef EPRISC_GPR_BYPASS_EN
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (bus.iWrEn[w] && wrMap[w].valid && (wrAddr[w] == rdAddr[r])) begin
                        rdNext[r] = bus.iWrData[w*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge iClk) begin
        for (int r = 0; r < RD_PORTS; r++) begin
            if (iRst) begin
                rdQ[r] <= '0;
            end else if (bus.iRdEn[r]) begin
                rdQ[r] <= rdNext[r];
            end
        end
    end

    always_comb begin
        rdFlat = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            rdFlat[r*DATA_W +: DATA_W] = rdQ[r];
        end
    end

    assign bus.oRdData = rdFlat;

endmodule
